// File: rtl/noc_tdm_pkg.sv
// Shared TDM slot-table definitions reused by the NCM, routers and NIs.
package noc_tdm_pkg;

  localparam int unsigned DEF_MAX_PORTS = 8;
  localparam int unsigned DEF_LUT_SIZE  = 8;

  // Idle / no-connection code for a table entry with max_ports ports.
  function automatic int unsigned slot_idle(input int unsigned max_ports);
    return max_ports;
  endfunction

  // Width of a port-select entry (ports plus the idle code).
  function automatic int unsigned port_sel_w(input int unsigned max_ports);
    return $clog2(max_ports + 1);
  endfunction

  // Width of a slot index.
  function automatic int unsigned slot_w(input int unsigned lut_size);
    return $clog2(lut_size);
  endfunction

  typedef logic [$clog2(DEF_MAX_PORTS + 1)-1:0] port_sel_t;
  typedef logic [$clog2(DEF_LUT_SIZE)-1:0]      slot_t;

  // Configuration write addressed to this node.
  function automatic logic conf_hit(input int unsigned node, input int unsigned id);
    return node == id;
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Free-running TDM slot counter, wraps at LUT_SIZE-1 for any size >= 2.
module tdm_slot_counter #(
  parameter int unsigned LUT_SIZE = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic [$clog2(LUT_SIZE)-1:0] slot
);

  localparam int unsigned SW = $clog2(LUT_SIZE);

  // Advance one slot per cycle, wrapping explicitly for non-power-of-2 sizes.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot <= '0;
    end else if (slot == SW'(LUT_SIZE - 1)) begin
      slot <= '0;
    end else begin
      slot <= slot + SW'(1);
    end
  end

endmodule

// File: rtl/tdm_slot_table.sv
// Per-node TDM slot table: filters config-bus writes for this node, stores
// per-output-port input selections, and presents the current slot's selection.
module tdm_slot_table
  import noc_tdm_pkg::*;
#(
  parameter int unsigned LUT_SIZE  = 8,
  parameter int unsigned MAX_PORTS = 8,
  parameter int unsigned X         = 3,
  parameter int unsigned Y         = 3,
  parameter int unsigned NODE_ID   = 0,
  parameter int unsigned IS_NI     = 0
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic [$clog2(MAX_PORTS+1)-1:0]                    lut_conf_data,
  input  logic [$clog2(MAX_PORTS)-1:0]                      lut_conf_sel,
  input  logic [$clog2(LUT_SIZE)-1:0]                       lut_conf_slot,
  input  logic [$clog2(X*Y)-1:0]                            config_node,
  input  logic                                              lut_conf_valid,
  input  logic                                              lut_conf_valid_ni,
  input  logic                                              link_en_valid,
  output logic [$clog2(LUT_SIZE)-1:0]                       cur_slot,
  output logic [MAX_PORTS-1:0][$clog2(MAX_PORTS+1)-1:0]     slot_sel,
  output logic [MAX_PORTS-1:0]                              slot_active,
  output logic [MAX_PORTS-1:0]                              link_en
);

  localparam int unsigned NODES = X * Y;
  localparam int unsigned DW    = $clog2(MAX_PORTS + 1);
  localparam logic [DW-1:0] IDLE = DW'(slot_idle(MAX_PORTS));

  // Held in flops: every port's entry for the current slot is read each cycle.
  logic [DW-1:0] lut_q [MAX_PORTS][LUT_SIZE];

  logic          node_hit;
  logic          tbl_we;
  logic          link_we;
  logic [DW-1:0] wdata;

  tdm_slot_counter #(
    .LUT_SIZE (LUT_SIZE)
  ) u_slot_counter (
    .clk  (clk),
    .rst  (rst),
    .slot (cur_slot)
  );

  // Decode write acceptance and clamp out-of-range data to the idle code.
  always_comb begin
    node_hit = 1'b0;
    tbl_we   = 1'b0;
    link_we  = 1'b0;
    wdata    = lut_conf_data;
    node_hit = conf_hit(32'(config_node), NODE_ID) && (NODES > 0);
    tbl_we   = ((IS_NI != 0) ? lut_conf_valid_ni : lut_conf_valid)
               && node_hit
               && (32'(lut_conf_sel) < MAX_PORTS)
               && (32'(lut_conf_slot) < LUT_SIZE);
    link_we  = link_en_valid && node_hit && (32'(lut_conf_sel) < MAX_PORTS);
    if (32'(lut_conf_data) > MAX_PORTS) begin
      wdata = IDLE;
    end
  end

  // Table storage; reset idles every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < int'(MAX_PORTS); p++) begin
        for (int s = 0; s < int'(LUT_SIZE); s++) begin
          lut_q[p][s] <= IDLE;
        end
      end
    end else if (tbl_we) begin
      lut_q[lut_conf_sel][lut_conf_slot] <= wdata;
    end
  end

  // Per-port link enables, independent of table writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      link_en <= '0;
    end else if (link_we) begin
      link_en[lut_conf_sel] <= lut_conf_data[0];
    end
  end

  // Current-slot lookup for every output port, straight from the registers.
  always_comb begin
    slot_sel    = '0;
    slot_active = '0;
    for (int p = 0; p < int'(MAX_PORTS); p++) begin
      slot_sel[p]    = lut_q[p][cur_slot];
      slot_active[p] = (lut_q[p][cur_slot] != IDLE) && link_en[p];
    end
  end

endmodule

// File: doc/tdm_slot_table.md
# tdm_slot_table

Receive side of the NoC control module's slot-table configuration bus; one instance sits in every router (`IS_NI=0`) and every network interface (`IS_NI=1`). It filters configuration writes addressed to its node and stores them in a per-output-port TDM lookup table. A free-running slot counter indexes that table, so the block presents, for every output port, the input selected in the current slot. It also holds the per-port link-enable register that the same bus writes via `link_en_valid`.

## Interface
Parameters:
- `LUT_SIZE`, 8: TDM slots per period; any value ≥2, power of 2 not required.
- `MAX_PORTS`, 8: ports per table; encoding value `MAX_PORTS` means idle / no connection.
- `X`, 3 and `Y`, 3: mesh size; `NODES = X*Y` (localparam).
- `NODE_ID`, 0: this node's index, compared against `config_node`.
- `IS_NI`, 0: 0 selects `lut_conf_valid` as table-write strobe; 1 selects `lut_conf_valid_ni`.

Ports:
- `clk` in 1: single clock for all state. One clock; reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `lut_conf_data` in `$clog2(MAX_PORTS+1)`: selected input port, or idle code.
- `lut_conf_sel` in `$clog2(MAX_PORTS)`: output port being configured.
- `lut_conf_slot` in `$clog2(LUT_SIZE)`: slot being configured.
- `config_node` in `$clog2(NODES)`: target node.
- `lut_conf_valid` in 1: router table-write strobe.
- `lut_conf_valid_ni` in 1: NI table-write strobe.
- `link_en_valid` in 1: link-enable write strobe; `lut_conf_data[0]` is the enable value.
- `cur_slot` out `$clog2(LUT_SIZE)`: current slot.
- `slot_sel` out `[MAX_PORTS-1:0][$clog2(MAX_PORTS+1)-1:0]`: per-output-port input selection for `cur_slot`.
- `slot_active` out `MAX_PORTS`: per port, `slot_sel != MAX_PORTS` and `link_en` is set.
- `link_en` out `MAX_PORTS`: registered link enables.

## Operation
- Write accept: requires the strobe selected by `IS_NI`, `config_node == NODE_ID`, `lut_conf_sel < MAX_PORTS` and `lut_conf_slot < LUT_SIZE`.
- Accepted write: `table[lut_conf_sel][lut_conf_slot] <= lut_conf_data`.
- `lut_conf_data > MAX_PORTS`: stored as `MAX_PORTS` (idle).
- Link-enable write: requires `link_en_valid`, node match and `lut_conf_sel < MAX_PORTS`. Effect: `link_en[lut_conf_sel] <= lut_conf_data[0]`. `lut_conf_slot` is ignored.
- Table write and link-enable write in the same cycle: both are applied, since they target independent storage.
- Mismatched node or out-of-range fields: write dropped silently, no state change.
- Slot counter: `cur_slot` increments every cycle. It wraps from `LUT_SIZE-1` to 0 and free-runs regardless of configuration activity.
- Outputs `slot_sel[p] = table[p][cur_slot]` and `slot_active` are combinational from registers (no extra pipeline stage).

## Timing
- Reset values: every table entry = `MAX_PORTS` (idle); `link_en = 0`; `cur_slot = 0`. Therefore `slot_sel` = all `MAX_PORTS` and `slot_active = 0`.
- First cycle after `rst` deasserts: `cur_slot = 0`.
- Write latency: a write sampled at edge t is visible on outputs from cycle t+1.
- Write to the slot that is current in cycle t: cycle t shows the old value; the new value appears at that slot's next occurrence.
- Exception: when `LUT_SIZE == 1`-like adjacency applies (the written slot equals `cur_slot` at t+1), the new value shows in cycle t+1.
- `link_en` change: `slot_active` updates in cycle t+1.
- `rst` asserted mid-period: the next edge clears the table, links and counter. Configuration writes in the reset cycle are discarded.
- No handshake or backpressure: the bus is fire-and-forget; every strobe is evaluated in the cycle it is high.

## Structure
- Shared package `noc_tdm_pkg`:
  - `SLOT_IDLE` encoding rule (= `MAX_PORTS`).
  - Typedef helpers for the port-select and slot widths.
  - Function `conf_hit(node, id)`.
  - These items are reused by the NCM and the NI.
- Sub-module `tdm_slot_counter`: parameter `LUT_SIZE`; ports `clk`, `rst`, `slot`; wrap logic for non-power-of-2 sizes. The NI instantiates it standalone.
- The table is implemented as flops (`MAX_PORTS*LUT_SIZE` entries), not inferred RAM, because all ports are read every cycle.

## Test plan
- Reset, then run 20 cycles: `cur_slot` sequence 0..7,0..7,0..3; `slot_sel` all 8; `slot_active` = 0; `link_en` = 0.
- `LUT_SIZE=5` instance: `cur_slot` wraps 4→0; a write to slot 7 is ignored and no entry changes.
- `NODE_ID=4`: write node 4, sel 2, slot 3, data 5, plus link write sel 2, data 1. Result: `slot_sel[2]=5` and `slot_active[2]=1` only while `cur_slot==3`. The same write with `config_node=5` causes no change.
- Write `data=12` (> `MAX_PORTS`) to node 4, sel 1, slot 0: entry reads 8 (idle); `slot_active[1]=0`.
- Table write and link write (sel 0, data 0) in the same cycle: both apply; `link_en[0]=0` and `slot_active[0]=0` even though the entry is non-idle.
- `IS_NI=1`: `lut_conf_valid` alone causes no write, `lut_conf_valid_ni` causes a write. Then assert `rst` mid-period: all entries idle and `cur_slot=0` on the next cycle.
